// File: rtl/axi_wr_burst_master.sv
// ---------------------------------------------------------------------------
// axi_wr_burst_master
//
// Turns write-burst requests from the I/O controller into AXI4 AW
// transactions, cuts the incoming 64 B/beat data stream into W bursts of the
// matching lengths (with WLAST), and counts outstanding B responses.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 job start pulse, clears the sticky error flag
//   wr_req/wr_req_ack     request handshake (ack is a one-cycle pulse)
//   wr_len, wr_address    burst length (beats-1) and start address
//   bready_en             permission to accept B responses
//   din_*                 decompressed data stream (valid/ready)
//   m_aw*, m_w*, m_b*     AXI4 write-channel master signals
//   wr_idle               nothing pending, in flight or awaiting a response
//   resp_err              sticky: a non-OKAY B response was seen
// ---------------------------------------------------------------------------
// AW FSM states
//   state    | meaning
//   AW_IDLE  | no AW outstanding, may accept a new request
//   AW_VALID | AW presented, waiting for m_awready
// ---------------------------------------------------------------------------
module axi_wr_burst_master #(
  parameter int DATA_W   = 512,
  parameter int ADDR_W   = 64,
  parameter int LFIFO_AW = 3,
  parameter int OUTS_W   = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                wr_req,
  output logic                wr_req_ack,
  input  logic [7:0]          wr_len,
  input  logic [ADDR_W-1:0]   wr_address,
  input  logic                bready_en,
  input  logic [DATA_W-1:0]   din_data,
  input  logic                din_valid,
  output logic                din_ready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic                wr_idle,
  output logic                resp_err
);

  localparam int LFIFO_D = 1 << LFIFO_AW;
  localparam logic [LFIFO_AW:0] PTR_ONE  = 1;
  localparam logic [OUTS_W-1:0] OUTS_ONE = 1;
  localparam logic [OUTS_W-1:0] OUTS_MAX = '1;

  typedef enum logic {
    AW_IDLE  = 1'b0,
    AW_VALID = 1'b1
  } aw_state_t;

  aw_state_t aw_state, aw_state_nxt;
  logic      accept;

  // burst-length FIFO: one entry per accepted request, popped on WLAST
  logic [7:0]        fifo_mem [LFIFO_D];
  logic [LFIFO_AW:0] wr_ptr, rd_ptr;
  logic              fifo_empty, fifo_full;
  logic [7:0]        head_len;
  logic              fifo_pop;

  logic [7:0]        beat_cnt;
  logic              active;
  logic              w_hs;

  logic [OUTS_W-1:0] outstanding;
  logic              aw_hs;
  logic              b_take;

  // -------------------------------------------------------------------------
  // constant AXI attributes
  // -------------------------------------------------------------------------
  assign m_awsize  = 3'd6;
  assign m_awburst = 2'b01;
  assign m_wstrb   = '1;
  assign m_bready  = bready_en;

  // -------------------------------------------------------------------------
  // FIFO status
  // -------------------------------------------------------------------------
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[LFIFO_AW] != rd_ptr[LFIFO_AW]) &&
                      (wr_ptr[LFIFO_AW-1:0] == rd_ptr[LFIFO_AW-1:0]);
  assign head_len   = fifo_mem[rd_ptr[LFIFO_AW-1:0]];

  // -------------------------------------------------------------------------
  // AW FSM
  // -------------------------------------------------------------------------
  always_comb begin
    aw_state_nxt = aw_state;
    accept       = 1'b0;
    case (aw_state)
      AW_IDLE: begin
        // saturated outstanding count blocks new AWs so it cannot wrap
        if (wr_req && !fifo_full && (outstanding != OUTS_MAX)) begin
          accept       = 1'b1;
          aw_state_nxt = AW_VALID;
        end
      end
      AW_VALID: begin
        if (m_awready) aw_state_nxt = AW_IDLE;
      end
      default: aw_state_nxt = AW_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_state   <= AW_IDLE;
      m_awaddr   <= '0;
      m_awlen    <= '0;
      wr_req_ack <= 1'b0;
    end else begin
      aw_state   <= aw_state_nxt;
      wr_req_ack <= accept;
      if (accept) begin
        m_awaddr <= wr_address;
        m_awlen  <= wr_len;
      end
    end
  end

  // AW_VALID always lasts at least one cycle, which spaces acks >= 2 apart
  assign m_awvalid = (aw_state == AW_VALID);
  assign aw_hs     = m_awvalid & m_awready;

  // -------------------------------------------------------------------------
  // W path: beats may flow as soon as the length is queued, ahead of AW
  // -------------------------------------------------------------------------
  assign active    = !fifo_empty;
  assign m_wvalid  = din_valid & active;
  assign din_ready = m_wready & active;
  assign m_wdata   = din_data;
  assign m_wlast   = active & (beat_cnt == head_len);
  assign w_hs      = m_wvalid & m_wready;
  assign fifo_pop  = w_hs & m_wlast;

  always_ff @(posedge clk) begin
    if (accept) fifo_mem[wr_ptr[LFIFO_AW-1:0]] <= wr_len;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      if (accept)   wr_ptr <= wr_ptr + PTR_ONE;
      if (fifo_pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (fifo_pop)  beat_cnt <= '0;
      else if (w_hs) beat_cnt <= beat_cnt + 8'd1;
    end
  end

  // -------------------------------------------------------------------------
  // B path and status
  // -------------------------------------------------------------------------
  // a response arriving with nothing outstanding is dropped entirely
  assign b_take = m_bvalid & m_bready & (outstanding != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      resp_err    <= 1'b0;
      wr_idle     <= 1'b1;
    end else begin
      case ({aw_hs, b_take})
        2'b10:   outstanding <= outstanding + OUTS_ONE;
        2'b01:   outstanding <= outstanding - OUTS_ONE;
        default: outstanding <= outstanding;
      endcase
      if (start)                            resp_err <= 1'b0;
      else if (b_take && m_bresp != 2'b00)  resp_err <= 1'b1;
      wr_idle <= (aw_state == AW_IDLE) && fifo_empty && (outstanding == '0);
    end
  end

endmodule
